spike_pair_encoder: RTL and testbench
=====================================

// Module: spike_pair_encoder
// PURPOSE
//   Upstream stimulus stage for the two-input AND spiking network.
//   Converts a latched 2-bit logic operand into per-channel spike trains. Each pulse is
//   a one-cycle d_out strobe, with s_out carrying the operand bit.
//   A fixed quiet window follows each train so the downstream neurons can leak back to
//   rest before the next operand. Replaces hand-timed bench stimulus with a reusable,
//   cycle-exact source.
// PARAMETERS
//   N_PULSE  4  pulses per channel per operand, 1..15
//   GAP      1  idle cycles between consecutive pulse slots, 0..15
//   STAGGER  1  1: last ch2 pulse moves one slot after last ch1 pulse; 0: aligned
//   QUIET    5  silent cycles after final pulse, before done, 0..255
// PORTS
//   clk      in   1  system clock, all logic on rising edge
//   rst      in   1  synchronous reset, active-high
//   start    in   1  request: latch bit_1/bit_2 and emit one train
//   bit_1    in   1  operand bit for channel 1 (sampled with start)
//   bit_2    in   1  operand bit for channel 2 (sampled with start)
//   busy     out  1  train in progress, start ignored
//   done     out  1  one-cycle pulse, train and quiet window complete
//   d_out_1  out  1  channel 1 spike strobe (feeds d_in_1)
//   s_out_1  out  1  channel 1 spike value (feeds s_in_1)
//   d_out_2  out  1  channel 2 spike strobe (feeds d_in_2)
//   s_out_2  out  1  channel 2 spike value (feeds s_in_2)
// BEHAVIOUR
//   - One clock (clk); reset is synchronous, active-high (rst).
//   - All outputs registered.
//   - Reset values: busy=0, done=0, d_out_*=0, s_out_*=0, FSM=IDLE, counters=0.
//   - FSM states: IDLE -> PULSE <-> GAPW -> [LAST2] -> QUIETW -> DONE -> IDLE.
//   - Start acceptance: start is accepted at edge E0 only if busy==0 (IDLE or DONE state).
//     bit_1/bit_2 are latched at E0. A start while busy==1 is dropped with no side effect.
//   - Slot timing: counted from the cycle after E0 (cycle 1).
//     Pulse slots fall on cycles 1 + k*(GAP+1).
//   - Aligned pulses: for k = 0..N_PULSE-2, both channels pulse in the same cycle.
//     The pulse at k = N_PULSE-1 also pulses both channels when STAGGER=0.
//   - Staggered last pulse (STAGGER=1): at k = N_PULSE-1 only ch1 pulses. LAST2 then
//     emits the ch2 pulse at slot k = N_PULSE.
//   - Pulse cycle: d_out_x=1 and s_out_x=latched bit_x. In every other cycle d_out_x=0
//     and s_out_x=0, so s_out is never high without d_out.
//   - GAP=0: pulses are back-to-back and GAPW is skipped.
//   - Quiet window: QUIETW holds all outputs 0 for QUIET cycles after the final pulse.
//   - Completion: DONE lasts one cycle with done=1, busy=0. A start in the DONE cycle is
//     accepted, and its first pulse follows in the next cycle (no dead cycle).
//   - busy=1 from cycle 1 through the last QUIETW cycle.
//   - Length: last pulse cycle L = 1 + (N_PULSE-1+STAGGER)*(GAP+1).
//     done is asserted at cycle L+QUIET+1.
//   - Mid-train reset: rst overrides everything. All outputs are 0 after that edge, the
//     FSM returns to IDLE, and no done is issued. A start in the same cycle as rst is
//     ignored.
//   - Counters: slot counter is 4 bits, gap counter is 4 bits, quiet counter is 8 bits.
//     All counters saturate/clear at state exit and never wrap mid-train.
// TESTING
//   1. Reset: hold rst 3 cycles with start=1 -> all outputs 0, busy=0, no pulses.
//   2. Operand 11, defaults, start at E0 -> ch1 pulses with s=1 on cycles 1,3,5,7.
//      ch2 pulses with s=1 on cycles 1,3,5,9. done on cycle 15. Downstream o1/o2 fire.
//   3. Operand 01, defaults -> d_out_1 pulses with s_out_1=0 throughout.
//      s_out_2=1 exactly on cycles 1,3,5,9.
//   4. STAGGER=0, GAP=0, N_PULSE=3, QUIET=2, operand 10 -> both channels pulse on
//      cycles 1,2,3 and done on cycle 6. Then start again in the done cycle -> next
//      pulse on cycle 7.
//   5. Start re-asserted on cycles 2-6 during a train -> ignored, latched bits
//      unchanged, timing identical to test 2.
//   6. rst on cycle 4 of a train -> outputs 0 on cycle 5, busy=0, no done.
//      A new start then gives a full, correct train.

Source files
------------

// File: rtl/spike_pair_encoder_if.sv
// Handshake and spike-output bundle between a stimulus controller and spike_pair_encoder.
interface spike_pair_encoder_if;
  logic start;
  logic bit_1;
  logic bit_2;
  logic busy;
  logic done;
  logic d_out_1;
  logic s_out_1;
  logic d_out_2;
  logic s_out_2;

  modport master (
    output start, bit_1, bit_2,
    input  busy, done, d_out_1, s_out_1, d_out_2, s_out_2
  );

  modport slave (
    input  start, bit_1, bit_2,
    output busy, done, d_out_1, s_out_1, d_out_2, s_out_2
  );
endinterface

// File: rtl/spike_pair_encoder.sv
// Turns a latched 2-bit operand into two cycle-exact spike trains followed by a quiet
// window, for driving the two-input AND spiking network.

module spike_lane (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic bit_val,
  output logic d_out,
  output logic s_out
);
  // s_out is gated by fire so a value never appears without its strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= 1'b0;
      s_out <= 1'b0;
    end else begin
      d_out <= fire;
      s_out <= fire & bit_val;
    end
  end
endmodule

module spike_pair_encoder #(
  parameter int unsigned N_PULSE = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned STAGGER = 1,
  parameter int unsigned QUIET   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_pair_encoder_if.slave  bus
);
  localparam int NUM_LANES = 2;

  localparam logic [3:0] SLOT_LAST  = 4'(N_PULSE - 1);
  localparam logic [3:0] GAP_LAST   = 4'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [7:0] QUIET_LAST = 8'((QUIET == 0) ? 0 : QUIET - 1);
  localparam bit         STAG_EN    = (STAGGER != 0);
  localparam bit         GAP_EN     = (GAP != 0);
  localparam bit         QUIET_EN   = (QUIET != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE  = 3'd1,
    GAPW   = 3'd2,
    LAST2  = 3'd3,
    QUIETW = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            slot_q, slot_d;
  logic [3:0]            gap_q, gap_d;
  logic [7:0]            quiet_q, quiet_d;
  logic [NUM_LANES-1:0]  bits_q, bits_d;
  logic [NUM_LANES-1:0]  fire_d;
  logic [NUM_LANES-1:0]  d_q, s_q;
  logic                  busy_q, done_q;

  // State register: state_q names what the registered outputs show this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 4'd0;
      gap_q   <= 4'd0;
      quiet_q <= 8'd0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      quiet_q <= quiet_d;
      bits_q  <= bits_d;
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    quiet_d = quiet_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        slot_d  = 4'd0;
        gap_d   = 4'd0;
        quiet_d = 8'd0;
        if (bus.start) begin
          state_d = PULSE;
          bits_d  = {bus.bit_2, bus.bit_1};
        end
      end
      PULSE: begin
        if (slot_q == SLOT_LAST) begin
          if (STAG_EN) begin
            state_d = GAP_EN ? GAPW : LAST2;
            if (!GAP_EN) slot_d = 4'd0;
          end else begin
            state_d = QUIET_EN ? QUIETW : DONE;
            slot_d  = 4'd0;
          end
        end else if (GAP_EN) begin
          state_d = GAPW;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      GAPW: begin
        if (gap_q == GAP_LAST) begin
          gap_d = 4'd0;
          if (slot_q == SLOT_LAST) begin
            state_d = LAST2;
            slot_d  = 4'd0;
          end else begin
            state_d = PULSE;
            slot_d  = slot_q + 4'd1;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      LAST2: begin
        state_d = QUIET_EN ? QUIETW : DONE;
      end
      QUIETW: begin
        if (quiet_q == QUIET_LAST) begin
          quiet_d = 8'd0;
          state_d = DONE;
        end else begin
          quiet_d = quiet_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = 4'd0;
        gap_d   = 4'd0;
        quiet_d = 8'd0;
      end
    endcase
  end

  // Channel 2 sits out the final PULSE slot when staggered and fires from LAST2 instead
  always_comb begin
    fire_d    = '0;
    fire_d[0] = (state_d == PULSE);
    fire_d[1] = ((state_d == PULSE) && !(STAG_EN && (slot_d == SLOT_LAST)))
              || (state_d == LAST2);
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      spike_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .fire    (fire_d[i]),
        .bit_val (bits_d[i]),
        .d_out   (d_q[i]),
        .s_out   (s_q[i])
      );
    end
  endgenerate

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.d_out_1 = d_q[0];
  assign bus.s_out_1 = s_q[0];
  assign bus.d_out_2 = d_q[1];
  assign bus.s_out_2 = s_q[1];
endmodule

// File: tb/tb_spike_pair_encoder.sv
// Scoreboard bench for spike_pair_encoder: default-parameter and short-train instances.
module tb_spike_pair_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_pair_encoder_if ifa ();
  spike_pair_encoder_if ifb ();

  spike_pair_encoder dut_a (.clk(clk), .rst(rst), .bus(ifa));
  spike_pair_encoder #(.N_PULSE(3), .GAP(0), .STAGGER(0), .QUIET(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] sb_q[$];
  logic [5:0] exp_v;

  // {busy, done, d_out_1, s_out_1, d_out_2, s_out_2} for cycle c after the start edge
  function automatic logic [5:0] exp_vec(int c, int np, int g, int st, int q,
                                         logic b1, logic b2);
    int l, d, k;
    logic p1, p2;
    l = 1 + (np - 1 + st) * (g + 1);
    d = l + q + 1;
    if (c < 1 || c > d) return 6'b0;
    if (c == d) return 6'b010000;
    p1 = 1'b0;
    p2 = 1'b0;
    if ((c - 1) % (g + 1) == 0) begin
      k  = (c - 1) / (g + 1);
      p1 = (k <= np - 1);
      p2 = (k <= np - 2) || (k == np - 1 && st == 0) || (k == np && st == 1);
    end
    return {1'b1, 1'b0, p1, p1 & b1, p2, p2 & b2};
  endfunction

  function automatic int train_len(int np, int g, int st, int q);
    return 1 + (np - 1 + st) * (g + 1) + q + 1;
  endfunction

  task automatic push_train(int np, int g, int st, int q, logic b1, logic b2, bit trail);
    int d;
    d = train_len(np, g, st, q) + (trail ? 1 : 0);
    for (int c = 1; c <= d; c++) sb_q.push_back(exp_vec(c, np, g, st, q, b1, b2));
  endtask

  function automatic logic [5:0] obs_a();
    return {ifa.busy, ifa.done, ifa.d_out_1, ifa.s_out_1, ifa.d_out_2, ifa.s_out_2};
  endfunction

  function automatic logic [5:0] obs_b();
    return {ifb.busy, ifb.done, ifb.d_out_1, ifb.s_out_1, ifb.d_out_2, ifb.s_out_2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b1; ifa.bit_1 = 1'b1; ifa.bit_2 = 1'b1;
    ifb.start = 1'b1; ifb.bit_1 = 1'b1; ifb.bit_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_a() !== 6'b0) begin
        n_errors++;
        $display("FAIL reset_a cyc %0d: got %b want 000000", i, obs_a());
      end
      n_checks++;
      if (obs_b() !== 6'b0) begin
        n_errors++;
        $display("FAIL reset_b cyc %0d: got %b want 000000", i, obs_b());
      end
    end
    rst = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    step();
    n_checks++;
    if (obs_a() !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got %b want 000000", obs_a());
    end
  endtask

  task automatic test_operand(string name, logic b1, logic b2);
    int c;
    ifa.bit_1 = b1; ifa.bit_2 = b2; ifa.start = 1'b1;
    push_train(4, 1, 1, 5, b1, b2, 1'b1);
    step();
    ifa.start = 1'b0;
    c = 1;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL %s cyc %0d: got %b want %b", name, c, obs_a(), exp_v);
      end
      step();
      c++;
    end
  endtask

  task automatic test_back_to_back();
    int c;
    ifb.bit_1 = 1'b1; ifb.bit_2 = 1'b0; ifb.start = 1'b1;
    push_train(3, 0, 0, 2, 1'b1, 1'b0, 1'b0);
    step();
    ifb.start = 1'b0;
    c = 1;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_b() !== exp_v) begin
        n_errors++;
        $display("FAIL b2b cyc %0d: got %b want %b", c, obs_b(), exp_v);
      end
      if (c == 6) begin
        ifb.bit_1 = 1'b0; ifb.bit_2 = 1'b1; ifb.start = 1'b1;
        push_train(3, 0, 0, 2, 1'b0, 1'b1, 1'b1);
      end
      step();
      if (c == 6) ifb.start = 1'b0;
      c++;
    end
  endtask

  task automatic test_start_ignored();
    int c;
    ifa.bit_1 = 1'b1; ifa.bit_2 = 1'b1; ifa.start = 1'b1;
    push_train(4, 1, 1, 5, 1'b1, 1'b1, 1'b1);
    step();
    ifa.start = 1'b0;
    c = 1;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL start_ignored cyc %0d: got %b want %b", c, obs_a(), exp_v);
      end
      // start held high during cycles 2..6 with a different operand
      ifa.start = (c >= 1 && c <= 5);
      ifa.bit_1 = 1'b0; ifa.bit_2 = 1'b0;
      step();
      c++;
    end
    ifa.start = 1'b0;
  endtask

  task automatic test_mid_reset();
    int c;
    ifa.bit_1 = 1'b1; ifa.bit_2 = 1'b1; ifa.start = 1'b1;
    push_train(4, 1, 1, 5, 1'b1, 1'b1, 1'b0);
    step();
    ifa.start = 1'b0;
    for (c = 1; c <= 4; c++) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL mid_reset_pre cyc %0d: got %b want %b", c, obs_a(), exp_v);
      end
      if (c == 4) begin
        rst = 1'b1;
        ifa.start = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    ifa.start = 1'b0;
    sb_q.delete();
    repeat (20) sb_q.push_back(6'b0);
    c = 5;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL mid_reset_quiet cyc %0d: got %b want %b", c, obs_a(), exp_v);
      end
      step();
      c++;
    end
    ifa.bit_1 = 1'b0; ifa.bit_2 = 1'b1; ifa.start = 1'b1;
    push_train(4, 1, 1, 5, 1'b0, 1'b1, 1'b1);
    step();
    ifa.start = 1'b0;
    c = 1;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== exp_v) begin
        n_errors++;
        $display("FAIL mid_reset_restart cyc %0d: got %b want %b", c, obs_a(), exp_v);
      end
      step();
      c++;
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.bit_1 = 1'b0; ifa.bit_2 = 1'b0;
    ifb.start = 1'b0; ifb.bit_1 = 1'b0; ifb.bit_2 = 1'b0;
    test_reset();
    test_operand("op11", 1'b1, 1'b1);
    test_operand("op01", 1'b0, 1'b1);
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
